// File: rtl/sqrt_iterative.sv
// sqrt_iterative
// Multi-cycle unsigned integer / fixed-point square root. Each clock
// produces one root bit using a non-restoring recurrence. A single fix-up
// cycle then makes the remainder non-negative.
//
// Parameters:
//   N  - radicand width (even, >= 4)
//   F  - fractional root bits (0..N/2); result width RW = N/2 + F
//
// Ports:
//   clk, reset      - clock; synchronous active-low reset
//   flush           - synchronous abort of any in-flight operation
//   in_valid/ready  - radicand handshake; in_data is the unsigned radicand X
//   out_valid/ready - result handshake; outputs hold under backpressure
//   out_root        - floor(sqrt(X * 4^F)), F fractional bits
//   out_rem         - X * 4^F - out_root^2 (0 .. 2*out_root)
//   out_exact       - out_rem == 0
module sqrt_iterative #(
    parameter  int N  = 32,
    parameter  int F  = 0,
    localparam int RW = N / 2 + F,
    localparam int CW = $clog2(RW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_root,
    output logic [RW:0]   out_rem,
    output logic          out_exact
);

    if ((N % 2) != 0 || N < 4) begin : g_bad_n
        $error("sqrt_iterative: N must be even and >= 4");
    end
    if (F < 0 || F > N / 2) begin : g_bad_f
        $error("sqrt_iterative: F must lie in 0..N/2");
    end

    // The radicand is consumed two bits per step, so it is held
    // left-justified in a 2*RW-bit register. The low 2F bits are zero,
    // which scales X by 4^F.
    localparam int SHW = 2 * RW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  sh_q, sh_d;
    logic [RW+1:0]   rem_q, rem_d;      // two's complement partial remainder
    logic [RW-1:0]   root_q, root_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [RW-1:0]   out_root_q, out_root_d;
    logic [RW:0]     out_rem_q, out_rem_d;
    logic            out_exact_q, out_exact_d;

    logic            accept;
    logic [1:0]      pair;
    logic [RW+1:0]   rem_sh;
    logic [RW+1:0]   rem_step;
    logic [RW+1:0]   rem_fix;

    assign in_ready  = (state_q == S_IDLE) && reset;
    // Flush wins over a same-edge handshake: the operand is dropped.
    assign accept    = in_valid && in_ready && !flush;

    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign out_exact = out_exact_q;

    // One non-restoring step. The sign of the previous remainder picks
    // subtract {root,01} or add {root,11}. Bits shifted out of rem_q's top
    // are harmless: the true remainder always fits RW+2 bits, so the
    // modular result is exact.
    always_comb begin
        pair     = sh_q[SHW-1 -: 2];
        rem_sh   = {rem_q[RW-1:0], pair};
        rem_step = rem_q[RW+1] ? (rem_sh + {root_q, 2'b11})
                               : (rem_sh - {root_q, 2'b01});
        // A negative final remainder is restored by adding 2*root+1. The
        // root's last bit is already 0 in that case.
        rem_fix  = rem_q[RW+1] ? (rem_q + {1'b0, root_q, 1'b1}) : rem_q;
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_root_d  = out_root_q;
        out_rem_d   = out_rem_q;
        out_exact_d = out_exact_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d    = SHW'(in_data) << (2 * F);
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sh_d   = {sh_q[SHW-3:0], 2'b00};
                rem_d  = rem_step;
                root_d = {root_q[RW-2:0], ~rem_step[RW+1]};
                if (cnt_q == CW'(RW - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                rem_d       = rem_fix;
                out_root_d  = root_q;
                out_rem_d   = rem_fix[RW:0];
                out_exact_d = (rem_fix == '0);
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                // No same-edge re-accept: IDLE is entered first.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result registers are left alone so a flushed op cannot disturb
        // the last delivered result.
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_rem_q   <= '0;
            out_exact_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_root_q  <= out_root_d;
            out_rem_q   <= out_rem_d;
            out_exact_q <= out_exact_d;
        end
    end

endmodule

// File: tb/tb_sqrt_iterative.sv
// Self-checking bench for sqrt_iterative. One instance uses N=32/F=0 and
// another N=8/F=4. Both are compared against a bit-greedy floor-sqrt
// model.
module tb_sqrt_iterative;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, sel;
    logic [31:0] in_data;

    logic        in_ready32, out_valid32, out_exact32;
    logic [15:0] out_root32;
    logic [16:0] out_rem32;
    logic        in_ready8, out_valid8, out_exact8;
    logic [7:0]  out_root8;
    logic [8:0]  out_rem8;

    logic        m_in_ready, m_out_valid, m_out_exact;
    logic [63:0] m_root, m_rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_iterative #(.N(32), .F(0)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid && !sel), .in_ready(in_ready32), .in_data(in_data),
        .out_valid(out_valid32), .out_ready(out_ready && !sel),
        .out_root(out_root32), .out_rem(out_rem32), .out_exact(out_exact32)
    );

    sqrt_iterative #(.N(8), .F(4)) dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid && sel), .in_ready(in_ready8), .in_data(in_data[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready && sel),
        .out_root(out_root8), .out_rem(out_rem8), .out_exact(out_exact8)
    );

    assign m_in_ready  = sel ? in_ready8   : in_ready32;
    assign m_out_valid = sel ? out_valid8  : out_valid32;
    assign m_out_exact = sel ? out_exact8  : out_exact32;
    assign m_root      = sel ? 64'(out_root8) : 64'(out_root32);
    assign m_rem       = sel ? 64'(out_rem8)  : 64'(out_rem32);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // floor(sqrt(v)) by setting root bits greedily from the top.
    function automatic logic [63:0] isqrt(input logic [63:0] v, input int rw);
        logic [63:0] r, t;
        r = 0;
        for (int b = rw - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    function automatic int cur_rw();
        return sel ? 8 : 16;
    endfunction

    function automatic logic [63:0] scaled(input logic [31:0] x);
        return sel ? (64'(x[7:0]) << 8) : 64'(x);
    endfunction

    // Present x and return at the negedge after the accepting edge.
    task automatic accept(input logic [31:0] x, input bit keep);
        int n;
        n = 0;
        in_data  = x;
        in_valid = 1'b1;
        while (!m_in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 60), 64'd1);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
        in_data = $urandom;  // must not affect the running op
    endtask

    // Called at the negedge after the accept edge; checks latency and result.
    task automatic wait_result(input logic [31:0] x);
        int lat;
        logic [63:0] v, r;
        lat = 0;
        while (!m_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(cur_rw() + 1));
        v = scaled(x);
        r = isqrt(v, cur_rw());
        chk("root", m_root, r);
        chk("rem", m_rem, v - r * r);
        chk("exact", 64'(m_out_exact), 64'(v == r * r));
    endtask

    task automatic run_op(input logic [31:0] x, input int stall);
        logic [63:0] v, r;
        out_ready = (stall == 0);
        accept(x, 1'b0);
        wait_result(x);
        v = scaled(x);
        r = isqrt(v, cur_rw());
        for (int i = 0; i < stall; i++) begin
            in_valid = $urandom_range(0, 1);
            @(negedge clk);
            chk("hold_valid", 64'(m_out_valid), 64'd1);
            chk("hold_root", m_root, r);
            chk("hold_rem", m_rem, v - r * r);
            chk("hold_in_ready", 64'(m_in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", 64'(m_out_valid), 64'd0);
        chk("ready_back", 64'(m_in_ready), 64'd1);
    endtask

    initial begin : main
        int k;
        bit seen;
        logic [31:0] x;

        sel = 1'b0; reset = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(m_in_ready), 64'd0);
        chk("rst_valid", 64'(m_out_valid), 64'd0);
        chk("rst_root", m_root, 64'd0);
        chk("rst_rem", m_rem, 64'd0);
        chk("rst_exact", 64'(m_out_exact), 64'd0);
        reset = 1'b1;
        #1 chk("rel_in_ready", 64'(m_in_ready), 64'd1);

        // Single op with no backpressure.
        run_op(32'd144, 0);
        chk("t1_root", m_root, 64'd12);
        chk("t1_exact", 64'(m_out_exact), 64'd1);

        // Back-to-back with in_valid held; second accept lands at edge 19.
        out_ready = 1'b1;
        accept(32'd0, 1'b1);
        in_data = 32'hFFFF_FFFF;
        wait_result(32'd0);
        k = 17;
        while (!m_in_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_accept_gap", 64'(k + 1), 64'd19);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        wait_result(32'hFFFF_FFFF);
        chk("max_root", m_root, 64'hFFFF);
        chk("max_rem", m_rem, 64'h1FFFE);
        @(negedge clk);

        // Backpressure.
        run_op(32'd1000, 6);
        chk("bp_root", m_root, 64'd31);
        chk("bp_rem", m_rem, 64'd39);

        // Flush mid-CALC.
        out_ready = 1'b1;
        accept(32'd50, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 64'(m_in_ready), 64'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= m_out_valid;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        // Flush in IDLE suppresses the capture.
        in_valid = 1'b1; in_data = 32'd7; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_accept", 64'(m_in_ready), 64'd1);
        run_op(32'd49, 0);
        chk("t5_root", m_root, 64'd7);

        // Reset while in DONE.
        out_ready = 1'b0;
        accept(32'd9, 1'b0);
        wait_result(32'd9);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rdone_valid", 64'(m_out_valid), 64'd0);
        chk("rdone_root", m_root, 64'd0);
        chk("rdone_rem", m_rem, 64'd0);
        chk("rdone_exact", 64'(m_out_exact), 64'd0);
        chk("rdone_in_ready", 64'(m_in_ready), 64'd0);
        reset = 1'b1;
        #1 chk("rdone_release", 64'(m_in_ready), 64'd1);
        run_op(32'd3, 0);
        chk("t6_rem", m_rem, 64'd2);

        // Reset mid-CALC.
        out_ready = 1'b1;
        accept(32'd77, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rcalc_release", 64'(m_in_ready), 64'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= m_out_valid;
        end
        chk("rcalc_no_result", 64'(seen), 64'd0);

        // Random N=32 ops with occasional stalls.
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            if (i % 10 == 3) x = x >> $urandom_range(4, 28);
            run_op(x, $urandom_range(0, 2));
        end

        // N=8, F=4 instance.
        sel = 1'b1;
        @(negedge clk);
        run_op(32'd2, 0);
        chk("f_root", m_root, 64'h16);
        chk("f_rem", m_rem, 64'd28);
        run_op(32'h90, 0);
        chk("f_root2", m_root, 64'hC0);
        run_op(32'd0, 1);
        run_op(32'hFF, 0);
        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
